// File: rtl/pharmacy_queue_ctrl_pkg.sv
// Shared encodings for the pharmacy queue front-end: heap mode codes,
// controller states and the ID/timestamp widths the heap compares.
package pharmacy_queue_ctrl_pkg;

  localparam int ID_W = 5;
  localparam int TS_W = 5;

  localparam logic [1:0] MODE_LIST    = 2'd0;
  localparam logic [1:0] MODE_IDLE    = 2'd1;
  localparam logic [1:0] MODE_CHECKIN = 2'd2;
  localparam logic [1:0] MODE_DELETE  = 2'd3;

  typedef enum logic [2:0] {
    IDLE,
    INS,
    PEEK,
    DEL,
    LST0,
    LIST
  } state_t;

endpackage

// File: rtl/pharmacy_queue_ctrl_if.sv
// Bus between the queue controller and the PharmacyMem min-heap.
// The controller drives the command side; the heap answers with list data and status.
interface pharmacy_queue_ctrl_if;
  import pharmacy_queue_ctrl_pkg::*;

  logic [ID_W-1:0] student_id;
  logic [1:0]      mode;
  logic [7:0]      check_in_time;
  logic [ID_W-1:0] list_output;
  logic            list_busy;
  logic            ready;

  modport master (
    output student_id, mode, check_in_time,
    input  list_output, list_busy, ready
  );

  modport slave (
    input  student_id, mode, check_in_time,
    output list_output, list_busy, ready
  );

endinterface

// File: rtl/pharmacy_queue_ctrl_rr_arbiter.sv
// Round-robin arbiter for the check-in kiosks. The search begins one past the
// last kiosk that was served, and the pointer only moves when the controller
// actually accepts or rejects the granted request.
module pharmacy_queue_ctrl_rr_arbiter #(
  parameter int N = 4
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic [N-1:0] req,
  input  logic         advance,
  output logic [N-1:0] grant,
  output logic         any
);

  localparam int IW = $clog2(N);

  logic [IW-1:0] last;
  logic [IW-1:0] grant_idx;

  // Pick the first requester after the last served kiosk, wrapping around.
  always_comb begin
    logic [IW:0]   sum;
    logic [IW-1:0] cand;
    grant     = '0;
    grant_idx = '0;
    any       = 1'b0;
    sum       = '0;
    cand      = '0;
    for (int k = 1; k <= N; k++) begin
      sum = {1'b0, last} + (IW+1)'(k);
      if (sum >= (IW+1)'(N)) sum = sum - (IW+1)'(N);
      cand = sum[IW-1:0];
      if (!any && req[cand]) begin
        any         = 1'b1;
        grant_idx   = cand;
        grant[cand] = 1'b1;
      end
    end
  end

  // Remember the served kiosk so the next search starts after it.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) last <= '0;
    else if (advance && any) last <= grant_idx;
  end

endmodule

// File: rtl/pharmacy_queue_ctrl.sv
// Front-end scheduler for the PharmacyMem min-heap: arbitrates kiosks, the
// dispense counter and the list port, sequences the heap mode protocol,
// stamps check-ins and tracks how many entries the heap holds.
module pharmacy_queue_ctrl
  import pharmacy_queue_ctrl_pkg::*;
#(
  parameter int N_KIOSK = 4,
  parameter int DEPTH   = 10
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic [N_KIOSK-1:0]      kiosk_req,
  input  logic [N_KIOSK*ID_W-1:0] kiosk_id,
  input  logic [N_KIOSK-1:0]      kiosk_urgent,
  output logic [N_KIOSK-1:0]      kiosk_ack,
  output logic [N_KIOSK-1:0]      kiosk_nack,
  input  logic                    disp_req,
  output logic                    disp_ack,
  output logic                    disp_nack,
  output logic [ID_W-1:0]         disp_id,
  input  logic                    list_req,
  output logic                    list_valid,
  output logic [ID_W-1:0]         list_id,
  output logic                    list_done,
  pharmacy_queue_ctrl_if.master   mem,
  output logic [3:0]              occupancy
);

  state_t state, state_next;

  logic [N_KIOSK-1:0] req_eff, grant, cur_grant;
  logic               any_req, advance, start_ins;
  logic               nack_kiosk, nack_disp, done_empty, list_finish, list_done_q;
  logic               disp_eff, list_eff;
  logic [ID_W-1:0]    sel_id, cur_id;
  logic               sel_urgent;
  logic [TS_W-1:0]    ts, cur_time;

  // A requester still sees its own response pulse for one cycle; masking it
  // there keeps a held level request from being served twice.
  assign req_eff  = kiosk_req & ~(kiosk_ack | kiosk_nack);
  assign disp_eff = disp_req & ~(disp_ack | disp_nack);
  assign list_eff = list_req & ~list_done_q;

  pharmacy_queue_ctrl_rr_arbiter #(.N(N_KIOSK)) u_arb (
    .clk     (clk),
    .rst_n   (rst_n),
    .req     (req_eff),
    .advance (advance),
    .grant   (grant),
    .any     (any_req)
  );

  // Route the granted kiosk's ID and urgency flag.
  always_comb begin
    sel_id     = '0;
    sel_urgent = 1'b0;
    for (int i = 0; i < N_KIOSK; i++) begin
      if (grant[i]) begin
        sel_id     = kiosk_id[i*ID_W +: ID_W];
        sel_urgent = kiosk_urgent[i];
      end
    end
  end

  assign mem.student_id    = cur_id;
  assign mem.check_in_time = {{(8-TS_W){1'b0}}, cur_time};
  assign list_valid        = (state == LIST) && mem.list_busy;
  assign list_id           = mem.list_output;
  assign list_done         = list_done_q | list_finish;

  // State register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_next;
  end

  // Arbitration, next state and heap mode decode.
  always_comb begin
    state_next  = state;
    mem.mode    = MODE_IDLE;
    advance     = 1'b0;
    start_ins   = 1'b0;
    nack_kiosk  = 1'b0;
    nack_disp   = 1'b0;
    done_empty  = 1'b0;
    list_finish = 1'b0;
    case (state)
      IDLE: begin
        if (disp_eff) begin
          if (occupancy == 4'd0) nack_disp = 1'b1;
          else                   state_next = PEEK;
        end else if (any_req) begin
          advance = 1'b1;
          if (occupancy == 4'(DEPTH)) nack_kiosk = 1'b1;
          else begin
            start_ins  = 1'b1;
            state_next = INS;
          end
        end else if (list_eff) begin
          if (occupancy == 4'd0) done_empty = 1'b1;
          else                   state_next = LST0;
        end
      end
      INS: begin
        mem.mode   = MODE_CHECKIN;
        state_next = IDLE;
      end
      PEEK: begin
        mem.mode   = MODE_LIST;
        state_next = DEL;
      end
      DEL: begin
        mem.mode   = MODE_DELETE;
        state_next = IDLE;
      end
      LST0: begin
        mem.mode   = MODE_LIST;
        state_next = LIST;
      end
      LIST: begin
        if (mem.list_busy) begin
          mem.mode = MODE_LIST;
        end else if (mem.ready) begin
          list_finish = 1'b1;
          state_next  = IDLE;
        end
      end
      default: state_next = IDLE;
    endcase
  end

  // Operand capture, occupancy/timestamp bookkeeping and response pulses.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      occupancy   <= '0;
      ts          <= '0;
      cur_grant   <= '0;
      cur_id      <= '0;
      cur_time    <= '0;
      kiosk_ack   <= '0;
      kiosk_nack  <= '0;
      disp_ack    <= 1'b0;
      disp_nack   <= 1'b0;
      disp_id     <= '0;
      list_done_q <= 1'b0;
    end else begin
      kiosk_ack   <= '0;
      kiosk_nack  <= '0;
      disp_ack    <= 1'b0;
      disp_nack   <= 1'b0;
      list_done_q <= done_empty;
      if (nack_disp)  disp_nack  <= 1'b1;
      if (nack_kiosk) kiosk_nack <= grant;
      if (start_ins) begin
        cur_grant <= grant;
        cur_id    <= sel_id;
        cur_time  <= sel_urgent ? '0 : ts;
      end
      if (state == INS) begin
        occupancy <= occupancy + 4'd1;
        ts        <= (ts == '1) ? ts : ts + 1'b1;
        kiosk_ack <= cur_grant;
      end
      if (state == DEL) begin
        disp_id   <= mem.list_output;
        occupancy <= occupancy - 4'd1;
        disp_ack  <= 1'b1;
        if (occupancy == 4'd1) ts <= '0;
      end
    end
  end

endmodule

// File: tb/tb_pharmacy_queue_ctrl.sv
// Directed bench for pharmacy_queue_ctrl with a behavioural min-heap standing in
// for PharmacyMem and queues holding the expected dispense/list/grant order.
module tb_pharmacy_queue_ctrl;
  import pharmacy_queue_ctrl_pkg::*;

  localparam int N_KIOSK = 4;
  localparam int DEPTH   = 10;

  logic clk   = 1'b0;
  logic rst_n = 1'b0;

  logic [N_KIOSK-1:0]      kiosk_req    = '0;
  logic [N_KIOSK*ID_W-1:0] kiosk_id     = '0;
  logic [N_KIOSK-1:0]      kiosk_urgent = '0;
  logic [N_KIOSK-1:0]      kiosk_ack, kiosk_nack;
  logic                    disp_req = 1'b0;
  logic                    disp_ack, disp_nack;
  logic [ID_W-1:0]         disp_id;
  logic                    list_req = 1'b0;
  logic                    list_valid, list_done;
  logic [ID_W-1:0]         list_id;
  logic [3:0]              occupancy;

  int checks   = 0;
  int failures = 0;
  int exp_disp[$];
  int exp_list[$];
  int exp_grant[$];

  always #5 clk = ~clk;

  pharmacy_queue_ctrl_if mem_bus ();

  pharmacy_queue_ctrl #(.N_KIOSK(N_KIOSK), .DEPTH(DEPTH)) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .kiosk_req    (kiosk_req),
    .kiosk_id     (kiosk_id),
    .kiosk_urgent (kiosk_urgent),
    .kiosk_ack    (kiosk_ack),
    .kiosk_nack   (kiosk_nack),
    .disp_req     (disp_req),
    .disp_ack     (disp_ack),
    .disp_nack    (disp_nack),
    .disp_id      (disp_id),
    .list_req     (list_req),
    .list_valid   (list_valid),
    .list_id      (list_id),
    .list_done    (list_done),
    .mem          (mem_bus),
    .occupancy    (occupancy)
  );

  // Behavioural heap: binary min-heap keyed on the 5-bit check-in time.
  logic [ID_W-1:0] h_id [16];
  logic [4:0]      h_t  [16];
  int              h_cnt  = 0;
  int              h_lidx = 0;
  logic            h_busy = 1'b0;
  logic [ID_W-1:0] h_out  = '0;

  assign mem_bus.list_output = h_out;
  assign mem_bus.list_busy   = h_busy;
  assign mem_bus.ready       = ~h_busy;

  always begin : heap_model
    int i, p, c;
    logic [ID_W-1:0] tid;
    logic [4:0]      tt;
    @(posedge clk or negedge rst_n);
    if (!rst_n) begin
      h_cnt  = 0;
      h_lidx = 0;
      h_busy <= 1'b0;
      h_out  <= '0;
    end else begin
      case (mem_bus.mode)
        2'd2: begin
          if (h_cnt < 16) begin
            i = h_cnt;
            h_id[4'(i)] = mem_bus.student_id;
            h_t[4'(i)]  = mem_bus.check_in_time[4:0];
            h_cnt = h_cnt + 1;
            while (i > 0) begin
              p = (i - 1) / 2;
              if (h_t[4'(i)] < h_t[4'(p)]) begin
                tid = h_id[4'(i)]; h_id[4'(i)] = h_id[4'(p)]; h_id[4'(p)] = tid;
                tt  = h_t[4'(i)];  h_t[4'(i)]  = h_t[4'(p)];  h_t[4'(p)]  = tt;
                i = p;
              end else begin
                i = 0;
              end
            end
          end
          h_busy <= 1'b0;
        end
        2'd3: begin
          if (h_cnt > 0) begin
            h_cnt = h_cnt - 1;
            h_id[0] = h_id[4'(h_cnt)];
            h_t[0]  = h_t[4'(h_cnt)];
            i = 0;
            for (int n = 0; n < 16; n++) begin
              c = 2 * i + 1;
              if (c >= h_cnt) break;
              if (c + 1 < h_cnt && h_t[4'(c+1)] < h_t[4'(c)]) c = c + 1;
              if (h_t[4'(c)] < h_t[4'(i)]) begin
                tid = h_id[4'(i)]; h_id[4'(i)] = h_id[4'(c)]; h_id[4'(c)] = tid;
                tt  = h_t[4'(i)];  h_t[4'(i)]  = h_t[4'(c)];  h_t[4'(c)]  = tt;
                i = c;
              end else begin
                break;
              end
            end
          end
          h_busy <= 1'b0;
        end
        2'd0: begin
          if (!h_busy) begin
            if (h_cnt > 0) begin
              h_busy <= 1'b1;
              h_out  <= h_id[0];
              h_lidx = 1;
            end
          end else if (h_lidx < h_cnt) begin
            h_out  <= h_id[4'(h_lidx)];
            h_lidx = h_lidx + 1;
          end else begin
            h_busy <= 1'b0;
          end
        end
        default: h_busy <= 1'b0;
      endcase
    end
  end

  task automatic check(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    checks++;
    assert (observed === expected) else begin
      failures++;
      $error("FAIL %s: observed %0d expected %0d", tag, observed, expected);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic applyCheckin(input int k, input int id, input bit urgent, input int exp_time);
    kiosk_id[k*ID_W +: ID_W] = ID_W'(id);
    kiosk_urgent[k] = urgent;
    kiosk_req[k]    = 1'b1;
    tick();
    check("ins_mode", 32'(mem_bus.mode), 32'(MODE_CHECKIN));
    check("ins_id",   32'(mem_bus.student_id), id);
    check("ins_time", 32'(mem_bus.check_in_time), exp_time);
    tick();
    check("kiosk_ack",  32'(kiosk_ack), 1 << k);
    check("kiosk_nack", 32'(kiosk_nack), 0);
    kiosk_req[k]    = 1'b0;
    kiosk_urgent[k] = 1'b0;
    tick();
  endtask

  task automatic applyCheckinFull(input int k, input int id);
    kiosk_id[k*ID_W +: ID_W] = ID_W'(id);
    kiosk_req[k] = 1'b1;
    tick();
    check("full_nack",      32'(kiosk_nack), 1 << k);
    check("full_no_ack",    32'(kiosk_ack), 0);
    check("full_mode_idle", 32'(mem_bus.mode), 32'(MODE_IDLE));
    check("full_occupancy", 32'(occupancy), DEPTH);
    check("full_heap_count", h_cnt, DEPTH);
    kiosk_req[k] = 1'b0;
    tick();
  endtask

  task automatic applyDispense();
    disp_req = 1'b1;
    tick();
    check("peek_mode", 32'(mem_bus.mode), 32'(MODE_LIST));
    tick();
    check("del_mode", 32'(mem_bus.mode), 32'(MODE_DELETE));
    tick();
    check("disp_ack", 32'(disp_ack), 1);
    if (exp_disp.size() > 0) check("disp_id", 32'(disp_id), exp_disp.pop_front());
    else                     check("disp_unexpected", 32'(disp_ack), 0);
    disp_req = 1'b0;
    tick();
  endtask

  task automatic applyDispenseEmpty();
    disp_req = 1'b1;
    tick();
    check("disp_nack",   32'(disp_nack), 1);
    check("disp_no_ack", 32'(disp_ack), 0);
    disp_req = 1'b0;
    tick();
  endtask

  task automatic checkOutput(input int n_expected);
    int  nvalid;
    bit  done_seen;
    nvalid    = 0;
    done_seen = 1'b0;
    list_req  = 1'b1;
    tick();
    check("lst0_mode", 32'(mem_bus.mode), 32'(MODE_LIST));
    for (int c = 0; c < 40 && !done_seen; c++) begin
      tick();
      if (list_valid) begin
        nvalid++;
        if (exp_list.size() > 0) check("list_id", 32'(list_id), exp_list.pop_front());
        else                     check("list_extra_valid", 32'(list_valid), 0);
      end
      if (list_done) begin
        done_seen = 1'b1;
        check("done_mode",  32'(mem_bus.mode), 32'(MODE_IDLE));
        check("done_valid", 32'(list_valid), 0);
        check("list_count", nvalid, n_expected);
      end
    end
    if (!done_seen) check("list_done_timeout", 32'(list_done), 1);
    list_req = 1'b0;
    tick();
  endtask

  initial begin
    int g, grants, next_id;

    // Reset state
    repeat (2) @(posedge clk);
    #1;
    check("rst_mode",      32'(mem_bus.mode), 32'(MODE_IDLE));
    check("rst_occupancy", 32'(occupancy), 0);
    check("rst_disp_id",   32'(disp_id), 0);
    check("rst_acks",      32'({kiosk_ack, kiosk_nack, disp_ack, disp_nack, list_done, list_valid}), 0);
    rst_n = 1'b1;
    tick();

    // Three check-ins, then three dispenses in arrival order, then an empty dispense
    applyCheckin(0, 7, 1'b0, 0);
    applyCheckin(1, 3, 1'b0, 1);
    applyCheckin(2, 9, 1'b0, 2);
    check("occ_after_3", 32'(occupancy), 3);
    exp_disp.push_back(7);
    exp_disp.push_back(3);
    exp_disp.push_back(9);
    repeat (3) applyDispense();
    applyDispenseEmpty();
    check("occ_after_drain", 32'(occupancy), 0);

    // Fill to capacity; the next request is rejected without touching the heap
    for (int i = 0; i < DEPTH; i++) applyCheckin(i % N_KIOSK, 10 + i, 1'b0, i);
    check("occ_full", 32'(occupancy), DEPTH);
    applyCheckinFull(3, 20);
    check("occ_full_hold", 32'(occupancy), DEPTH);
    for (int i = 0; i < DEPTH; i++) exp_disp.push_back(10 + i);
    repeat (DEPTH) applyDispense();
    check("occ_after_fill_drain", 32'(occupancy), 0);

    // All kiosks requesting continuously
    for (int k = 0; k < N_KIOSK; k++) kiosk_id[k*ID_W +: ID_W] = ID_W'(24 + k);
    exp_grant = '{0, 1, 2, 3, 0};
    next_id   = 28;
    grants    = 0;
    g         = 0;
    kiosk_req = '1;
    for (int c = 0; c < 60 && grants < 5; c++) begin
      tick();
      if (|kiosk_ack) begin
        for (int i = 0; i < N_KIOSK; i++) if (kiosk_ack[i]) g = i;
        if (exp_grant.size() > 0) check("rr_grant", g, exp_grant.pop_front());
        grants++;
        kiosk_id[g*ID_W +: ID_W] = ID_W'(next_id);
        next_id++;
      end
    end
    kiosk_req = '0;
    if (grants < 5) check("rr_timeout", grants, 5);
    tick();
    check("occ_after_rr", 32'(occupancy), 5);
    for (int i = 0; i < 4; i++) exp_disp.push_back(24 + i);
    repeat (4) applyDispense();

    // Urgent entry overtakes waiting ones
    applyCheckin(0, 1, 1'b0, 5);
    applyCheckin(1, 2, 1'b0, 6);
    applyCheckin(2, 21, 1'b1, 0);
    exp_disp.push_back(21);
    applyDispense();

    // Heap-order dump of four entries
    applyCheckin(3, 11, 1'b0, 8);
    check("occ_before_list", 32'(occupancy), 4);
    exp_list = '{28, 1, 2, 11};
    checkOutput(4);
    check("occ_after_list", 32'(occupancy), 4);
    exp_disp = '{28, 1, 2, 11};
    repeat (4) applyDispense();

    // Dump of an empty queue
    list_req = 1'b1;
    tick();
    check("empty_list_done",  32'(list_done), 1);
    check("empty_list_valid", 32'(list_valid), 0);
    list_req = 1'b0;
    tick();

    // Reset in the middle of a dump
    applyCheckin(0, 5, 1'b0, 0);
    applyCheckin(1, 6, 1'b0, 1);
    list_req = 1'b1;
    tick();
    tick();
    check("midlist_valid", 32'(list_valid), 1);
    rst_n = 1'b0;
    #1;
    check("midrst_mode",      32'(mem_bus.mode), 32'(MODE_IDLE));
    check("midrst_valid",     32'(list_valid), 0);
    check("midrst_done",      32'(list_done), 0);
    check("midrst_occupancy", 32'(occupancy), 0);
    check("midrst_disp_id",   32'(disp_id), 0);
    list_req = 1'b0;
    tick();
    rst_n = 1'b1;
    for (int c = 0; c < 3; c++) begin
      tick();
      check("post_rst_done", 32'(list_done), 0);
      check("post_rst_mode", 32'(mem_bus.mode), 32'(MODE_IDLE));
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
